inst_stream_encoder: RTL and testbench

// Encoder side of the opcode/field decode done by the CPU control unit. Accepts

---
 rtl/inst_stream_encoder.sv | 141 ++++++++++++++
 tb/tb_inst_stream_encoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_stream_encoder.sv
// Packs field-level instruction requests into RV32I words and streams them into
// instruction memory, one slot per request, closing the program with a halt pair.
module inst_stream_encoder #(
  parameter int          IMEM_ADDR_W = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [3:0]             req_kind,
  input  logic [2:0]             req_funct3,
  input  logic [6:0]             req_funct7,
  input  logic [4:0]             req_rd,
  input  logic [4:0]             req_rs1,
  input  logic [4:0]             req_rs2,
  input  logic [31:0]            req_imm,
  output logic                   imem_we,
  output logic [31:0]            imem_addr,
  output logic [31:0]            imem_wdata,
  output logic [IMEM_ADDR_W:0]   inst_count,
  output logic                   done,
  output logic                   bad_kind
);
  localparam int CW = IMEM_ADDR_W + 1;
  // Two slots stay free so the halt pair always fits.
  localparam logic [CW-1:0] SLOT_LIMIT = CW'(2**IMEM_ADDR_W - 2);

  localparam logic [3:0] K_ARITH     = 4'd0;
  localparam logic [3:0] K_ARITH_IMM = 4'd1;
  localparam logic [3:0] K_LOAD      = 4'd2;
  localparam logic [3:0] K_STORE     = 4'd3;
  localparam logic [3:0] K_BRANCH    = 4'd4;
  localparam logic [3:0] K_JAL       = 4'd5;
  localparam logic [3:0] K_JALR      = 4'd6;
  localparam logic [3:0] K_ECALL     = 4'd7;
  localparam logic [3:0] K_FINISH    = 4'd8;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [31:0] HALT_LI_WORD = 32'h00A00893;
  localparam logic [31:0] ECALL_WORD   = 32'h00000073;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_HALT_LI, S_HALT_EC, S_DONE} state_t;
  state_t state, state_nxt;

  logic        accept, is_finish, is_bad, is_shift;
  logic [31:0] enc, slot_addr;
  logic        unused_imm;

  assign unused_imm = ^req_imm[31:21];
  assign is_finish  = (req_kind == K_FINISH);
  assign is_bad     = (req_kind > K_FINISH);
  assign is_shift   = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);
  assign req_ready  = reset && (state == S_IDLE) &&
                      (is_finish || (inst_count < SLOT_LIMIT));
  assign accept     = req_valid && req_ready;
  assign slot_addr  = BASE_ADDR + 32'({inst_count, 2'b00});

  always_comb begin
    enc = 32'h0;
    case (req_kind)
      K_ARITH:     enc = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, OP_R};
      K_ARITH_IMM: enc = is_shift ?
                         {req_funct7, req_imm[4:0], req_rs1, req_funct3, req_rd, OP_I} :
                         {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_I};
      K_LOAD:      enc = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_LOAD};
      K_STORE:     enc = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OP_STORE};
      K_BRANCH:    enc = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                          req_imm[4:1], req_imm[11], OP_BRANCH};
      K_JAL:       enc = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
      K_JALR:      enc = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
      K_ECALL:     enc = ECALL_WORD;
      default:     enc = 32'h0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) begin
                   if (is_finish)   state_nxt = S_HALT_LI;
                   else if (!is_bad) state_nxt = S_WRITE;
                 end
      S_WRITE:   state_nxt = S_IDLE;
      S_HALT_LI: state_nxt = S_HALT_EC;
      S_HALT_EC: state_nxt = S_DONE;
      S_DONE:    state_nxt = S_DONE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Write port is registered: the strobe cycle is the one after acceptance,
  // and the slot is counted at the edge that ends it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'h0;
      inst_count <= '0;
      done       <= 1'b0;
      bad_kind   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          if (is_bad) begin
            bad_kind <= 1'b1;
          end else begin
            imem_we    <= 1'b1;
            imem_addr  <= slot_addr;
            imem_wdata <= is_finish ? HALT_LI_WORD : enc;
          end
        end
        S_WRITE: inst_count <= inst_count + 1'b1;
        S_HALT_LI: begin
          inst_count <= inst_count + 1'b1;
          imem_we    <= 1'b1;
          imem_addr  <= imem_addr + 32'd4;
          imem_wdata <= ECALL_WORD;
        end
        S_HALT_EC: begin
          inst_count <= inst_count + 1'b1;
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_stream_encoder.sv
// Scoreboard bench: a large-memory instance takes directed and random requests, a
// four-slot instance exercises the reserved halt slots.
module tb_inst_stream_encoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  vld;
  logic        rdy0, rdy1;
  logic [3:0]  kind;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        we0, we1, done0, done1, bad0, bad1;
  logic [31:0] addr0, addr1, wd0, wd1;
  logic [10:0] cnt0;
  logic [2:0]  cnt1;

  inst_stream_encoder #(.IMEM_ADDR_W(10), .BASE_ADDR(32'h0)) u_dut (
    .clk(clk), .reset(reset), .req_valid(vld[0]), .req_ready(rdy0),
    .req_kind(kind), .req_funct3(f3), .req_funct7(f7), .req_rd(rd),
    .req_rs1(rs1), .req_rs2(rs2), .req_imm(imm),
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(wd0),
    .inst_count(cnt0), .done(done0), .bad_kind(bad0));

  inst_stream_encoder #(.IMEM_ADDR_W(2), .BASE_ADDR(32'h100)) u_small (
    .clk(clk), .reset(reset), .req_valid(vld[1]), .req_ready(rdy1),
    .req_kind(kind), .req_funct3(f3), .req_funct7(f7), .req_rd(rd),
    .req_rs1(rs1), .req_rs2(rs2), .req_imm(imm),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1),
    .inst_count(cnt1), .done(done1), .bad_kind(bad1));

  int checks = 0;
  int errors = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] e0, e1;
  int          m_count[2];
  logic [31:0] m_base[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_rdy(input int d);
    return (d == 0) ? rdy0 : rdy1;
  endfunction
  function automatic logic [31:0] get_cnt(input int d);
    return (d == 0) ? 32'(cnt0) : 32'(cnt1);
  endfunction
  function automatic logic get_done(input int d);
    return (d == 0) ? done0 : done1;
  endfunction
  function automatic logic get_bad(input int d);
    return (d == 0) ? bad0 : bad1;
  endfunction

  function automatic void push(input int d, input logic [31:0] a, input logic [31:0] w);
    if (d == 0) q0.push_back({a, w});
    else        q1.push_back({a, w});
  endfunction

  // Reference encoder: each field placed at its RV32I bit position arithmetically.
  function automatic logic [31:0] bits(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'h1 << (hi - lo + 1)) - 1);
  endfunction

  function automatic logic [31:0] ref_enc(input logic [3:0] k, input logic [2:0] a3,
      input logic [6:0] a7, input logic [4:0] ard, input logic [4:0] ars1,
      input logic [4:0] ars2, input logic [31:0] im);
    logic [31:0] regs;
    regs = (32'(ars1) << 15) | (32'(a3) << 12);
    case (k)
      4'd0: return (32'(a7) << 25) | (32'(ars2) << 20) | regs | (32'(ard) << 7) | 32'h33;
      4'd1: if (a3 == 3'd1 || a3 == 3'd5)
              return (32'(a7) << 25) | (bits(im, 4, 0) << 20) | regs | (32'(ard) << 7) | 32'h13;
            else
              return (bits(im, 11, 0) << 20) | regs | (32'(ard) << 7) | 32'h13;
      4'd2: return (bits(im, 11, 0) << 20) | regs | (32'(ard) << 7) | 32'h03;
      4'd3: return (bits(im, 11, 5) << 25) | (32'(ars2) << 20) | regs |
                   (bits(im, 4, 0) << 7) | 32'h23;
      4'd4: return (bits(im, 12, 12) << 31) | (bits(im, 10, 5) << 25) | (32'(ars2) << 20) |
                   regs | (bits(im, 4, 1) << 8) | (bits(im, 11, 11) << 7) | 32'h63;
      4'd5: return (bits(im, 20, 20) << 31) | (bits(im, 10, 1) << 21) | (bits(im, 11, 11) << 20) |
                   (bits(im, 19, 12) << 12) | (32'(ard) << 7) | 32'h6F;
      4'd6: return (bits(im, 11, 0) << 20) | (32'(ars1) << 15) | (32'(ard) << 7) | 32'h67;
      default: return 32'h00000073;
    endcase
  endfunction

  always @(negedge clk) begin
    if (we0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0_unexpected_we: got addr %h data %h expected no write", addr0, wd0);
      end else begin
        e0 = q0.pop_front();
        check("dut0_addr", addr0, e0[63:32]);
        check("dut0_wdata", wd0, e0[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (we1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_we: got addr %h data %h expected no write", addr1, wd1);
      end else begin
        e1 = q1.pop_front();
        check("dut1_addr", addr1, e1[63:32]);
        check("dut1_wdata", wd1, e1[31:0]);
      end
    end
  end

  task automatic send(input int d, input logic [3:0] k, input logic [2:0] a3,
      input logic [6:0] a7, input logic [4:0] ard, input logic [4:0] ars1,
      input logic [4:0] ars2, input logic [31:0] im, input int max_wait, output bit acc);
    @(negedge clk);
    kind = k; f3 = a3; f7 = a7; rd = ard; rs1 = ars1; rs2 = ars2; imm = im;
    vld[d] = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < max_wait && !acc; i++) begin
      #1;
      if (get_rdy(d)) begin
        @(posedge clk);
        #1;
        acc = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    vld[d] = 1'b0;
  endtask

  task automatic issue(input int d, input logic [3:0] k, input logic [2:0] a3,
      input logic [6:0] a7, input logic [4:0] ard, input logic [4:0] ars1,
      input logic [4:0] ars2, input logic [31:0] im, input bit lit_en, input logic [31:0] lit);
    bit acc;
    send(d, k, a3, a7, ard, ars1, ars2, im, 40, acc);
    check("accepted", 32'(acc), 32'd1);
    if (!acc) return;
    if (k == 4'd8) begin
      push(d, m_base[d] + 32'(4 * m_count[d]), 32'h00A00893);
      push(d, m_base[d] + 32'(4 * (m_count[d] + 1)), 32'h00000073);
      m_count[d] += 2;
      repeat (2) @(negedge clk);
      check("done_not_early", 32'(get_done(d)), 32'd0);
      @(negedge clk);
      check("done_set", 32'(get_done(d)), 32'd1);
      check("ready_low_done", 32'(get_rdy(d)), 32'd0);
      check("count_after_halt", get_cnt(d), 32'(m_count[d]));
    end else if (k > 4'd8) begin
      @(negedge clk);
      check("bad_kind_set", 32'(get_bad(d)), 32'd1);
      check("count_after_bad", get_cnt(d), 32'(m_count[d]));
    end else begin
      push(d, m_base[d] + 32'(4 * m_count[d]),
           lit_en ? lit : ref_enc(k, a3, a7, ard, ars1, ars2, im));
      m_count[d]++;
      repeat (2) @(negedge clk);
      check("count", get_cnt(d), 32'(m_count[d]));
    end
  endtask

  task automatic issue_rand(input int d);
    issue(d, 4'($urandom_range(0, 7)), 3'($urandom), 7'($urandom), 5'($urandom),
          5'($urandom), 5'($urandom), $urandom, 1'b0, 32'h0);
  endtask

  function automatic void model_reset();
    m_count[0] = 0;
    m_count[1] = 0;
  endfunction

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    m_base[0] = 32'h0;
    m_base[1] = 32'h100;
    model_reset();
    vld = 2'b00; kind = 4'd0; f3 = 3'd0; f7 = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'h0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we", 32'(we0), 32'd0);
    check("rst_addr", addr0, 32'h0);
    check("rst_addr_small", addr1, 32'h100);
    check("rst_wdata", wd0, 32'h0);
    check("rst_count", 32'(cnt0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_bad", 32'(bad0), 32'd0);
    check("rst_ready", 32'(rdy0), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(rdy0), 32'd1);

    issue(0, 4'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 32'h002081B3);
    issue(0, 4'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b1, 32'hFE208CE3);
    issue(0, 4'd5, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b1, 32'h010000EF);
    issue(0, 4'd8, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0);
    send(0, 4'd0, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'h0, 5, acc);
    check("no_accept_in_done", 32'(acc), 32'd0);

    @(negedge clk); reset = 1'b0; model_reset();
    @(negedge clk); reset = 1'b1;
    check("done_cleared", 32'(done0), 32'd0);
    issue(0, 4'd6, 3'd7, 7'd0, 5'd0, 5'd1, 5'd0, 32'h0, 1'b1, 32'h00008067);
    for (int i = 0; i < 24; i++) issue_rand(0);
    issue(0, 4'd12, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0);
    issue_rand(0);
    issue(0, 4'd8, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0);

    // Reset coinciding with a valid request must not accept it.
    @(negedge clk);
    reset = 1'b0; kind = 4'd0; vld[0] = 1'b1; model_reset();
    #1 check("ready_in_rst_with_valid", 32'(rdy0), 32'd0);
    @(negedge clk);
    vld[0] = 1'b0; reset = 1'b1;
    check("bad_cleared", 32'(bad0), 32'd0);
    repeat (2) @(negedge clk);
    check("count_rst_valid", 32'(cnt0), 32'd0);

    // Reset during the strobe cycle drops the pending write.
    send(0, 4'd0, 3'd0, 7'd0, 5'd5, 5'd6, 5'd7, 32'h0, 40, acc);
    check("accepted_pre_rst", 32'(acc), 32'd1);
    push(0, 32'h0, ref_enc(4'd0, 3'd0, 7'd0, 5'd5, 5'd6, 5'd7, 32'h0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; model_reset();
    check("we_dropped", 32'(we0), 32'd0);
    check("count_dropped", 32'(cnt0), 32'd0);
    issue_rand(0);

    // Four-slot instance: two words, then only FINISH fits.
    issue_rand(1);
    issue_rand(1);
    send(1, 4'd0, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'h0, 6, acc);
    check("third_held", 32'(acc), 32'd0);
    issue(1, 4'd8, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0);

    repeat (3) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
